// File: rtl/vga_line_fetch_arb_pkg.sv
// Shared video constants and fetch-arbiter FSM encoding.
// Defaults size a 480x272 RGB565 frame held in a 17-bit word space.
package vga_line_fetch_arb_pkg;

  localparam int RD_H_DEF    = 480;
  localparam int RD_V_DEF    = 272;
  localparam int AW_DEF      = 17;
  localparam int DW_DEF      = 16;
  localparam int WR_SLOT_DEF = 8;
  localparam int PXW         = 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

endpackage

// File: rtl/vga_line_fetch_arb_if.sv
// Writer request, single-port memory and line-buffer write bundle.
// master: arbiter side (drives mem_*, wr_ack, lb_*); slave: peer side.
interface vga_line_fetch_arb_if
  import vga_line_fetch_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic           lb_we;
  logic           lb_bank;
  logic [PXW-1:0] lb_addr;
  logic [DW-1:0]  lb_wdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_rd, mem_we, mem_wdata,
    output lb_we, lb_bank, lb_addr, lb_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_rd, mem_we, mem_wdata,
    input  lb_we, lb_bank, lb_addr, lb_wdata
  );

endinterface

// File: rtl/vga_line_fetch_arb_slot.sv
// lfa_slot_counter: WR_SLOT modulo counter and writer grant decision.
// Ports: clk, rst_n, clr, en (fetching), idle, armed, wr_req -> grant.
module lfa_slot_counter #(
  parameter int WR_SLOT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic idle,
  input  logic armed,
  input  logic wr_req,
  output logic grant
);

  localparam int SW = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;
  localparam logic [SW-1:0] LAST = SW'(WR_SLOT - 1);

  logic [SW-1:0] slot;
  logic          at_last;

  assign at_last = (slot == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (en) begin
      slot <= at_last ? '0 : slot + 1'b1;
    end
  end

  // armed keeps the write strobe quiet while reset is held.
  assign grant = armed & wr_req & (idle | (en & at_last));

endmodule

// File: rtl/vga_line_fetch_arb.sv
// Fetches display lines from a shared single-port memory into a
// two-bank line buffer, giving a writer one slot in WR_SLOT.
// Ports: clk, rst_n, frame_start, line_start, bus (master),
// disp_bank, busy, underrun.
module vga_line_fetch_arb
  import vga_line_fetch_arb_pkg::*;
#(
  parameter int RD_H    = RD_H_DEF,
  parameter int RD_V    = RD_V_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int WR_SLOT = WR_SLOT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic line_start,
  vga_line_fetch_arb_if.master bus,
  output logic disp_bank,
  output logic busy,
  output logic underrun
);

  localparam int LW = $clog2(RD_V + 1);

  state_t         state;
  logic [LW-1:0]  line;
  logic [LW-1:0]  nl;
  logic [AW-1:0]  base;
  logic [PXW-1:0] px;
  logic           fbank;
  logic           armed;
  logic           grant;
  logic           rd;
  logic           last_rd;
  logic           fs;
  logic           ls;

  assign fs = frame_start;
  assign ls = line_start & ~frame_start;

  // An abort moves on to the line after the one being fetched.
  assign nl = (state != IDLE) ? line + 1'b1 : line;

  lfa_slot_counter #(
    .WR_SLOT(WR_SLOT)
  ) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fs | ls),
    .en    (state == FETCH),
    .idle  (state == IDLE),
    .armed (armed),
    .wr_req(bus.wr_req),
    .grant (grant)
  );

  assign rd      = (state == FETCH) & ~grant;
  assign last_rd = rd & (px == PXW'(RD_H - 1));

  assign bus.mem_rd    = rd;
  assign bus.mem_we    = grant;
  assign bus.wr_ack    = grant;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.mem_addr  = grant ? bus.wr_addr : base + AW'(px);
  assign bus.lb_wdata  = bus.mem_rdata;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      line      <= '0;
      base      <= '0;
      px        <= '0;
      fbank     <= 1'b0;
      disp_bank <= 1'b0;
      underrun  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (fs) begin
        line      <= '0;
        underrun  <= 1'b0;
        disp_bank <= 1'b1;
        fbank     <= 1'b0;
        base      <= '0;
        px        <= '0;
        state     <= FETCH;
      end else if (ls) begin
        disp_bank <= ~disp_bank;
        line      <= nl;
        if (state != IDLE) begin
          underrun <= 1'b1;
        end
        if (int'(nl) < RD_V) begin
          base  <= AW'(int'(nl) * RD_H);
          fbank <= disp_bank;
          px    <= '0;
          state <= FETCH;
        end else begin
          state <= IDLE;
        end
      end else begin
        unique case (state)
          IDLE: ;
          FETCH: begin
            if (rd) begin
              px <= px + 1'b1;
            end
            if (last_rd) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            state <= IDLE;
            line  <= line + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read data lands a cycle after mem_rd; the write follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lb_we   <= 1'b0;
      bus.lb_addr <= '0;
      bus.lb_bank <= 1'b0;
    end else begin
      bus.lb_we <= rd;
      if (rd) begin
        bus.lb_addr <= px;
        bus.lb_bank <= fbank;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_arb.sv
// Directed bench for vga_line_fetch_arb.
// Drives frame/line pulses and a writer; memory returns addr ^ 16'h5A3C.
module tb_vga_line_fetch_arb;

  logic clk;
  logic rst_n;
  logic frame_start;
  logic line_start;
  logic disp_bank;
  logic busy;
  logic underrun;

  int checks;
  int errors;
  int px;
  int exp_db;

  vga_line_fetch_arb_if #(.AW(17), .DW(16)) bus ();

  vga_line_fetch_arb #(
    .RD_H(480), .RD_V(272), .AW(17), .DW(16), .WR_SLOT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .line_start (line_start),
    .bus        (bus),
    .disp_bank  (disp_bank),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [16:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= pat(bus.mem_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    line_start = 1'b0;
    bus.wr_req = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (2) cyc();

    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_lb_we", bus.lb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp_bank", disp_bank, 0);
    chk("rst_underrun", underrun, 0);

    bus.wr_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) cyc();

    // line 0 with no writer
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("fs_disp_bank", disp_bank, 1);
    chk("fs_busy", busy, 1);
    chk("fs_lb_we0", bus.lb_we, 0);
    for (int i = 0; i < 480; i++) begin
      chk("l0_rd", bus.mem_rd, 1);
      chk("l0_addr", bus.mem_addr, i);
      if (i > 0) begin
        chk("l0_lb_we", bus.lb_we, 1);
        chk("l0_lb_addr", bus.lb_addr, i - 1);
        chk("l0_lb_bank", bus.lb_bank, 0);
        chk("l0_lb_wdata", bus.lb_wdata, pat(17'(i - 1)));
      end
      cyc();
    end
    chk("l0_drain_rd", bus.mem_rd, 0);
    chk("l0_drain_lb_we", bus.lb_we, 1);
    chk("l0_drain_lb_addr", bus.lb_addr, 479);
    chk("l0_drain_busy", busy, 1);
    cyc();
    chk("l0_done_busy", busy, 0);
    chk("l0_done_lb_we", bus.lb_we, 0);

    // line 1 with the writer always requesting
    bus.wr_addr = 17'h1ABCD;
    bus.wr_data = 16'hBEEF;
    bus.wr_req = 1'b1;
    line_start = 1'b1;
    #1;
    chk("idle_we", bus.mem_we, 1);
    chk("idle_ack", bus.wr_ack, 1);
    chk("idle_waddr", bus.mem_addr, 17'h1ABCD);
    chk("idle_rd", bus.mem_rd, 0);
    cyc();
    line_start = 1'b0;
    chk("l1_disp_bank", disp_bank, 0);
    px = 0;
    for (int j = 1; j <= 548; j++) begin
      if (j % 8 == 0) begin
        chk("wr_we", bus.mem_we, 1);
        chk("wr_ack", bus.wr_ack, 1);
        chk("wr_rd", bus.mem_rd, 0);
        chk("wr_addr", bus.mem_addr, 17'h1ABCD);
        chk("wr_data", bus.mem_wdata, 16'hBEEF);
      end else begin
        chk("wr_slot_rd", bus.mem_rd, 1);
        chk("wr_slot_we", bus.mem_we, 0);
        chk("wr_slot_addr", bus.mem_addr, 480 + px);
        px++;
      end
      if (j == 2) chk("l1_lb_bank", bus.lb_bank, 1);
      cyc();
    end
    chk("l1_drain_rd", bus.mem_rd, 0);
    chk("l1_drain_no_we", bus.mem_we, 0);
    chk("l1_drain_busy", busy, 1);
    chk("l1_drain_lb_addr", bus.lb_addr, 479);
    cyc();
    chk("l1_done_busy", busy, 0);
    chk("l1_idle_we", bus.mem_we, 1);
    bus.wr_req = 1'b0;

    // line 2 runs to completion, line 3 gets cut short
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    chk("l2_addr", bus.mem_addr, 960);
    repeat (485) cyc();
    chk("l2_done_busy", busy, 0);
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    chk("l3_disp_bank", disp_bank, 0);
    chk("l3_addr", bus.mem_addr, 1440);
    repeat (100) cyc();
    chk("l3_px100_addr", bus.mem_addr, 1540);
    chk("l3_underrun0", underrun, 0);
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    chk("ur_underrun", underrun, 1);
    chk("ur_rd", bus.mem_rd, 1);
    chk("ur_addr", bus.mem_addr, 1920);
    chk("ur_disp_bank", disp_bank, 1);
    chk("ur_lb_we", bus.lb_we, 1);
    chk("ur_lb_addr", bus.lb_addr, 100);
    chk("ur_lb_bank", bus.lb_bank, 1);
    cyc();
    chk("ur_next_lb_bank", bus.lb_bank, 0);
    chk("ur_next_lb_addr", bus.lb_addr, 0);
    chk("ur_next_addr", bus.mem_addr, 1921);

    // abort through the rest of the frame
    for (int k = 5; k <= 272; k++) begin
      line_start = 1'b1;
      cyc();
      line_start = 1'b0;
      if (k < 272) begin
        chk("run_addr", bus.mem_addr, k * 480);
        chk("run_rd", bus.mem_rd, 1);
      end else begin
        chk("end_rd", bus.mem_rd, 0);
        chk("end_busy", busy, 0);
      end
      cyc();
    end
    exp_db = 1;
    for (int n = 0; n < 3; n++) begin
      line_start = 1'b1;
      cyc();
      line_start = 1'b0;
      exp_db = 1 - exp_db;
      chk("post_rd", bus.mem_rd, 0);
      chk("post_busy", busy, 0);
      chk("post_disp_bank", disp_bank, exp_db);
      cyc();
      chk("post_rd2", bus.mem_rd, 0);
    end
    chk("post_underrun", underrun, 1);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("refs_underrun", underrun, 0);
    chk("refs_rd", bus.mem_rd, 1);
    chk("refs_addr", bus.mem_addr, 0);
    chk("refs_disp_bank", disp_bank, 1);

    // frame_start beats a coincident line_start
    repeat (485) cyc();
    chk("both_pre_busy", busy, 0);
    frame_start = 1'b1;
    line_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    line_start = 1'b0;
    chk("both_addr", bus.mem_addr, 0);
    chk("both_rd", bus.mem_rd, 1);
    chk("both_disp_bank", disp_bank, 1);
    chk("both_underrun", underrun, 0);
    cyc();
    chk("both_lb_bank", bus.lb_bank, 0);
    chk("both_lb_addr", bus.lb_addr, 0);
    repeat (485) cyc();
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    chk("both_next_addr", bus.mem_addr, 480);

    // reset in the middle of a fetch
    repeat (50) cyc();
    bus.wr_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", bus.mem_rd, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_ack", bus.wr_ack, 0);
    chk("mid_rst_lb_we", bus.lb_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_disp_bank", disp_bank, 0);
    cyc();
    chk("mid_rst_lb_we2", bus.lb_we, 0);
    chk("mid_rst_we2", bus.mem_we, 0);
    bus.wr_req = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rd", bus.mem_rd, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_lb_we", bus.lb_we, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
